// File: rtl/bnn_layer_sequencer.sv
// -----------------------------------------------------------------------------
// bnn_layer_sequencer
//
// Central controller for a chain of NUM_LAYERS binarised-NN layer blocks. It
// moves one frame through the chain one layer at a time. It launches layer k,
// waits for layer k to latch its inputs, waits for layer k's result, and then
// moves on to layer k+1. The upstream layer k-1 keeps its result held until
// layer k has been seen in its receive state. After the last layer, the result
// is presented to the classifier through done/done_ack.
//
// A per-step watchdog aborts into an error state when any layer-wait step
// stalls. A frame latency counter measures the cycles from start accept to
// DONE entry.
//
// Ports
//   clk           in   clock
//   xrst          in   asynchronous active-low reset
//   start         in   frame available at layer 0 input
//   start_ready   out  sequencer idle and layer 0 ready to take a frame
//   lyr_rcv_req   in   per-layer: layer idle, ready to latch new inputs
//   lyr_snd_ack   in   per-layer: layer in send state, outputs final
//   lyr_rcv_ack   out  per-layer one-cycle launch pulse
//   lyr_snd_req   out  per-layer: hold the layer's result
//   done          out  final-layer outputs valid
//   done_ack      in   consumer has taken the result
//   busy          out  frame in flight (not IDLE / ERR)
//   cur_layer     out  index of the active layer
//   err           out  watchdog fired
//   clr_err       in   leave the error state
//   cycle_count   out  cycles from start accept to DONE entry
// -----------------------------------------------------------------------------
module bnn_layer_sequencer #(
   parameter int NUM_LAYERS = 4,     // 2..8
   parameter int TIMEOUT    = 1023,  // watchdog limit, must fit in 10 bits
   parameter int CW         = 16
) (
   input  logic                  clk,
   input  logic                  xrst,
   input  logic                  start,
   output logic                  start_ready,
   input  logic [NUM_LAYERS-1:0] lyr_rcv_req,
   input  logic [NUM_LAYERS-1:0] lyr_snd_ack,
   output logic [NUM_LAYERS-1:0] lyr_rcv_ack,
   output logic [NUM_LAYERS-1:0] lyr_snd_req,
   output logic                  done,
   input  logic                  done_ack,
   output logic                  busy,
   output logic [2:0]            cur_layer,
   output logic                  err,
   input  logic                  clr_err,
   output logic [CW-1:0]         cycle_count
);

   localparam int             WDW      = 10;
   localparam logic [2:0]     LAST     = 3'(NUM_LAYERS - 1);
   localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_LATCH,
      S_COMPUTE,
      S_DONE,
      S_DRAIN,
      S_ERR
   } state_e;

   state_e                state_q, state_d;
   logic [2:0]            k_q, k_d;
   logic [NUM_LAYERS-1:0] snd_req_q, snd_req_d;
   logic                  err_q, err_d;
   logic [WDW-1:0]        wd_q, wd_d;
   logic [CW-1:0]         cnt_q, cnt_d;

   // One-hot select of the active layer and of its upstream neighbour.
   // Shifting the select right yields zero for k==0, so the release of
   // layer k-1 needs no special case for the first layer.
   logic [NUM_LAYERS-1:0] k_sel;
   logic [NUM_LAYERS-1:0] k_prev_sel;
   logic                  rcv_req_k;
   logic                  snd_ack_k;
   logic                  wd_run;
   logic [WDW-1:0]        wd_inc;
   logic                  counting;

   assign k_sel      = NUM_LAYERS'(1) << k_q;
   assign k_prev_sel = k_sel >> 1;
   assign rcv_req_k  = |(lyr_rcv_req & k_sel);
   assign snd_ack_k  = |(lyr_snd_ack & k_sel);

   // The watchdog only runs while the sequencer waits on a layer. IDLE and
   // DONE wait on external parties, and ERR waits for software.
   assign wd_run = (state_q == S_LAUNCH)  || (state_q == S_LATCH) ||
                   (state_q == S_COMPUTE) || (state_q == S_DRAIN);
   assign wd_inc = wd_q + WDW'(1);

   // ---------------------------------------------------------------------
   // Next-state and Moore outputs
   // ---------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable assigned here gets a default first, so no path
      // can leave one unassigned and infer a latch.
      state_d     = state_q;
      k_d         = k_q;
      snd_req_d   = snd_req_q;
      err_d       = err_q;
      lyr_rcv_ack = '0;

      case (state_q)
         S_IDLE: begin
            if (start && start_ready) begin
               k_d     = '0;
               state_d = S_LAUNCH;
            end
         end

         S_LAUNCH: begin
            // The pulse follows the layer's request combinationally. The
            // state leaves on the same edge, so it lasts exactly one cycle.
            lyr_rcv_ack = lyr_rcv_req & k_sel;
            if (rcv_req_k) begin
               state_d = S_LATCH;
            end
         end

         S_LATCH: begin
            // rcv_req low means layer k is latching at this edge. Only now
            // may the upstream layer drop the result it has been holding.
            if (!rcv_req_k) begin
               snd_req_d = (snd_req_q | k_sel) & ~k_prev_sel;
               state_d   = S_COMPUTE;
            end
         end

         S_COMPUTE: begin
            if (snd_ack_k) begin
               if (k_q == LAST) begin
                  state_d = S_DONE;
               end else begin
                  k_d     = k_q + 3'd1;
                  state_d = S_LAUNCH;
               end
            end
         end

         S_DONE: begin
            if (done_ack) begin
               snd_req_d = snd_req_q & ~k_sel;
               state_d   = S_DRAIN;
            end
         end

         S_DRAIN: begin
            if (!snd_ack_k) begin
               k_d     = '0;
               state_d = S_IDLE;
            end
         end

         S_ERR: begin
            if (clr_err) begin
               err_d   = 1'b0;
               k_d     = '0;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A regular transition on the same cycle wins over the watchdog. The
      // watchdog only aborts a step that would otherwise keep waiting.
      if (wd_run && (wd_inc == WD_LIMIT) && (state_d == state_q)) begin
         state_d   = S_ERR;
         err_d     = 1'b1;
         snd_req_d = '0;
      end
   end

   // ---------------------------------------------------------------------
   // Watchdog and frame latency counter
   // ---------------------------------------------------------------------
   // The latency counter runs only in the layer-walking states. It freezes
   // from DONE entry through DRAIN and IDLE, until the next accept clears it.
   assign counting = (state_q == S_LAUNCH) || (state_q == S_LATCH) ||
                     (state_q == S_COMPUTE);

   always_comb begin
      wd_d = wd_q;
      if (state_d != state_q) begin
         wd_d = '0;
      end else if (wd_run) begin
         wd_d = wd_inc;
      end

      cnt_d = cnt_q;
      if ((state_q == S_IDLE) && (state_d == S_LAUNCH)) begin
         cnt_d = '0;
      end else if (counting && (cnt_q != '1)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         state_q   <= S_IDLE;
         k_q       <= '0;
         snd_req_q <= '0;
         err_q     <= 1'b0;
         wd_q      <= '0;
         cnt_q     <= '0;
      end else begin
         // NOTE: registers use non-blocking assignments, so every register
         // samples the values from before the edge, whatever the order.
         state_q   <= state_d;
         k_q       <= k_d;
         snd_req_q <= snd_req_d;
         err_q     <= err_d;
         wd_q      <= wd_d;
         cnt_q     <= cnt_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign start_ready = (state_q == S_IDLE) && lyr_rcv_req[0];
   assign busy        = (state_q != S_IDLE) && (state_q != S_ERR);
   assign done        = (state_q == S_DONE);
   assign err         = err_q;
   assign cur_layer   = k_q;
   assign lyr_snd_req = snd_req_q;
   assign cycle_count = cnt_q;

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bnn_layer_sequencer
//
// Directed bench for bnn_layer_sequencer with four behavioural layer models.
// Each layer model is idle with rcv_req high. A launch pulse moves it to a
// one-cycle receive state, then to 330 cycles of compute, then to send
// (snd_ack high) until snd_req drops. Per-layer masks let the stimulus hold a
// layer's rcv_req or snd_ack low.
//
// Hand timing of one layer step, counted from its LAUNCH entry:
//   LAUNCH 1 + LATCH 1 + COMPUTE 331 (330 layer compute + 1 cycle to see
//   snd_ack) = 333 cycles.
// A full four-layer frame is therefore 1332 cycles.
// -----------------------------------------------------------------------------
module tb_bnn_layer_sequencer;

   localparam int NL        = 4;
   localparam int TO        = 1023;
   localparam int CWID      = 16;
   localparam int COMP_CYC  = 330;
   localparam int FRAME_CYC = 1332;

   logic            clk = 1'b0;
   logic            xrst;
   logic            start;
   logic            start_ready;
   logic [NL-1:0]   lyr_rcv_req;
   logic [NL-1:0]   lyr_snd_ack;
   logic [NL-1:0]   lyr_rcv_ack;
   logic [NL-1:0]   lyr_snd_req;
   logic            done;
   logic            done_ack;
   logic            busy;
   logic [2:0]      cur_layer;
   logic            err;
   logic            clr_err;
   logic [CWID-1:0] cycle_count;

   bnn_layer_sequencer #(
      .NUM_LAYERS (NL),
      .TIMEOUT    (TO),
      .CW         (CWID)
   ) dut (
      .clk         (clk),
      .xrst        (xrst),
      .start       (start),
      .start_ready (start_ready),
      .lyr_rcv_req (lyr_rcv_req),
      .lyr_snd_ack (lyr_snd_ack),
      .lyr_rcv_ack (lyr_rcv_ack),
      .lyr_snd_req (lyr_snd_req),
      .done        (done),
      .done_ack    (done_ack),
      .busy        (busy),
      .cur_layer   (cur_layer),
      .err         (err),
      .clr_err     (clr_err),
      .cycle_count (cycle_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------------------------------------------------------------
   // Layer models
   // ---------------------------------------------------------------------
   typedef enum logic [1:0] {L_IDLE, L_RECV, L_COMP, L_SEND} lyr_st_e;

   lyr_st_e       lst  [NL];
   int            lcnt [NL];
   logic [NL-1:0] model_rcv_req;
   logic [NL-1:0] model_snd_ack;
   logic [NL-1:0] rcv_mask;
   logic [NL-1:0] snd_mask;

   always @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         for (int i = 0; i < NL; i++) begin
            lst[i]  <= L_IDLE;
            lcnt[i] <= 0;
         end
      end else begin
         for (int i = 0; i < NL; i++) begin
            case (lst[i])
               L_IDLE: if (lyr_rcv_ack[i]) lst[i] <= L_RECV;
               L_RECV: begin
                  lst[i]  <= L_COMP;
                  lcnt[i] <= COMP_CYC - 1;
               end
               L_COMP: begin
                  if (lcnt[i] == 0) lst[i] <= L_SEND;
                  else              lcnt[i] <= lcnt[i] - 1;
               end
               L_SEND: if (!lyr_snd_req[i]) lst[i] <= L_IDLE;
               default: lst[i] <= L_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      model_rcv_req = '0;
      model_snd_ack = '0;
      for (int i = 0; i < NL; i++) begin
         model_rcv_req[i] = (lst[i] == L_IDLE);
         model_snd_ack[i] = (lst[i] == L_SEND);
      end
   end

   assign lyr_rcv_req = model_rcv_req & ~rcv_mask;
   assign lyr_snd_ack = model_snd_ack & ~snd_mask;

   // ---------------------------------------------------------------------
   // Frame monitor: counts launch-pulse cycles per layer, multi-hot pulses
   // and done rising edges, sampled on the falling edge.
   // ---------------------------------------------------------------------
   logic mon_clr;
   int   ack_hi [NL];
   int   multi_hot;
   int   done_rise;
   logic done_prev;

   always @(negedge clk) begin
      if (mon_clr) begin
         for (int i = 0; i < NL; i++) ack_hi[i] = 0;
         multi_hot = 0;
         done_rise = 0;
         done_prev = 1'b0;
      end else begin
         for (int i = 0; i < NL; i++) if (lyr_rcv_ack[i]) ack_hi[i]++;
         if ($countones(lyr_rcv_ack) > 1) multi_hot++;
         if (done && !done_prev) done_rise++;
         done_prev = done;
      end
   end

   // ---------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------
   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                  tag, got, got, exp, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Clears the monitor, then pulses start for one cycle. Returns the bench
   // cycle number of the first falling edge with the frame in flight.
   task automatic launch_frame(output int c_busy);
      mon_clr = 1'b1;
      tick();
      #1 mon_clr = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      c_busy = cyc;
      check("start_accepted", 32'(busy), 1);
   endtask

   task automatic wait_done(input int limit, output int c_done);
      int n;
      n = 0;
      while (!done && n < limit) begin
         tick();
         n++;
      end
      c_done = cyc;
      check("done_reached", 32'(done), 1);
   endtask

   task automatic wait_idle(input int limit, output int n);
      n = 0;
      while (busy && n < limit) begin
         tick();
         n++;
      end
      check("back_to_idle", 32'(busy), 0);
   endtask

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   initial begin
      int c_busy, c_done, c0, n, cnt, pulses, hold_ok;

      xrst     = 1'b0;
      start    = 1'b0;
      done_ack = 1'b1;
      clr_err  = 1'b0;
      rcv_mask = '0;
      snd_mask = '0;
      mon_clr  = 1'b1;

      // Reset state
      #1;
      check("rst_rcv_ack",     32'(lyr_rcv_ack), 0);
      check("rst_snd_req",     32'(lyr_snd_req), 0);
      check("rst_done",        32'(done),        0);
      check("rst_err",         32'(err),         0);
      check("rst_busy",        32'(busy),        0);
      check("rst_cycle_count", 32'(cycle_count), 0);
      check("rst_cur_layer",   32'(cur_layer),   0);
      tick();
      tick();
      xrst = 1'b1;
      tick();
      check("idle_start_ready", 32'(start_ready), 1);

      // Nominal frame with done_ack tied high, including the layer 0 -> 1
      // handoff ordering.
      launch_frame(c_busy);
      n = 0;
      while (!lyr_rcv_ack[1] && n < 2000) begin
         tick();
         n++;
      end
      check("ho_ack1_seen", 32'(lyr_rcv_ack[1]), 1);
      tick();
      check("ho_rcv_req1_low",  32'(lyr_rcv_req[1]), 0);
      check("ho_snd_req0_held", 32'(lyr_snd_req[0]), 1);
      check("ho_snd_ack0_held", 32'(lyr_snd_ack[0]), 1);
      tick();
      check("ho_snd_req0_released", 32'(lyr_snd_req[0]), 0);
      check("ho_snd_req1_set",      32'(lyr_snd_req[1]), 1);
      wait_done(3000, c_done);
      check("nom_cur_layer",      32'(cur_layer),   3);
      check("nom_cycle_count",    32'(cycle_count), FRAME_CYC);
      check("nom_cycle_vs_bench", 32'(cycle_count), 32'(c_done - c_busy));
      wait_idle(10, n);
      check("nom_start_ready", 32'(start_ready), 1);
      for (int i = 0; i < NL; i++) check($sformatf("nom_ack_pulse%0d", i), 32'(ack_hi[i]), 1);
      check("nom_multi_hot", 32'(multi_hot), 0);
      check("nom_done_rise", 32'(done_rise), 1);

      // done backpressure: consumer stalls for 500 cycles.
      done_ack = 1'b0;
      launch_frame(c_busy);
      wait_done(3000, c_done);
      check("bp_cycle_count", 32'(cycle_count), FRAME_CYC);
      hold_ok = 0;
      for (int i = 0; i < 500; i++) begin
         tick();
         if (done && !err && busy && (cycle_count == CWID'(FRAME_CYC))) hold_ok++;
      end
      check("bp_hold_cycles", 32'(hold_ok), 500);
      done_ack = 1'b1;
      tick();
      check("bp_snd_req3_drop", 32'(lyr_snd_req[3]), 0);
      check("bp_done_drop",     32'(done),           0);
      wait_idle(2, n);
      check("bp_idle_within_3", 32'(n + 1 <= 3), 1);

      // Watchdog: layer 2 never shows snd_ack.
      snd_mask[2] = 1'b1;
      launch_frame(c_busy);
      n = 0;
      while (!lyr_snd_req[2] && n < 2000) begin
         tick();
         n++;
      end
      check("wd_compute2_entered", 32'(lyr_snd_req[2]), 1);
      c0 = cyc;
      n  = 0;
      while (!err && n < TO + 50) begin
         tick();
         n++;
      end
      check("wd_err",          32'(err),            1);
      check("wd_latency",      32'(cyc - c0),       TO);
      check("wd_snd_req_zero", 32'(lyr_snd_req),    0);
      check("wd_rcv_ack_zero", 32'(lyr_rcv_ack),    0);
      check("wd_done_zero",    32'(done),           0);
      check("wd_busy_zero",    32'(busy),           0);
      check("wd_start_ready",  32'(start_ready),    0);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("wd_start_ignored", 32'({err, busy}), 32'b10);
      snd_mask = '0;
      clr_err  = 1'b1;
      tick();
      clr_err = 1'b0;
      check("wd_clr_err",       32'(err),         0);
      check("wd_clr_cur_layer", 32'(cur_layer),   0);
      tick();
      check("wd_clr_ready",     32'(start_ready), 1);
      launch_frame(c_busy);
      wait_done(3000, c_done);
      check("wd_next_frame_count", 32'(cycle_count), FRAME_CYC);
      wait_idle(10, n);

      // Launch stall: layer 1 keeps rcv_req low while k=1 sits in LAUNCH.
      rcv_mask[1] = 1'b1;
      launch_frame(c_busy);
      n = 0;
      while (cur_layer != 3'd1 && n < 1000) begin
         tick();
         n++;
      end
      check("ls_cur_layer1", 32'(cur_layer), 1);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (lyr_rcv_ack[1]) cnt++;
         tick();
      end
      check("ls_no_ack_while_low", 32'(cnt), 0);
      check("ls_still_layer1",     32'(cur_layer), 1);
      rcv_mask[1] = 1'b0;
      #1;
      pulses = lyr_rcv_ack[1] ? 1 : 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (lyr_rcv_ack[1]) pulses++;
      end
      check("ls_single_pulse", 32'(pulses), 1);
      wait_done(3000, c_done);
      check("ls_done_layer", 32'(cur_layer), 3);
      wait_idle(10, n);

      // Asynchronous reset in the middle of layer 2's compute.
      launch_frame(c_busy);
      n = 0;
      while (!(lyr_snd_req[2] && cur_layer == 3'd2) && n < 2000) begin
         tick();
         n++;
      end
      check("ar_in_compute2", 32'(cur_layer), 2);
      for (int i = 0; i < 10; i++) tick();
      #2 xrst = 1'b0;
      #1;
      check("ar_rcv_ack",     32'(lyr_rcv_ack), 0);
      check("ar_snd_req",     32'(lyr_snd_req), 0);
      check("ar_done",        32'(done),        0);
      check("ar_err",         32'(err),         0);
      check("ar_busy",        32'(busy),        0);
      check("ar_cur_layer",   32'(cur_layer),   0);
      check("ar_cycle_count", 32'(cycle_count), 0);
      tick();
      xrst = 1'b1;
      tick();
      check("ar_ready_follows_hi", 32'(start_ready), 1);
      rcv_mask[0] = 1'b1;
      #1;
      check("ar_ready_follows_lo", 32'(start_ready), 0);
      rcv_mask[0] = 1'b0;
      #1;
      check("ar_ready_restored", 32'(start_ready), 1);
      launch_frame(c_busy);
      wait_done(3000, c_done);
      check("ar_next_frame_count", 32'(cycle_count), FRAME_CYC);
      wait_idle(10, n);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Global time limit so the bench always terminates.
   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got simulation still running, expected completion");
      $fatal(1, "global timeout");
   end

endmodule
